crc16_tx_gen: RTL and testbench

Transmit-side USB CRC16 generator. It accumulates the CRC over payload bits as the serializer shifts them out. On command, it emits the 16 complemented CRC bits MSB-first on the same bit strobe, so the packet ends with a valid CRC16 field. It sits between the TX data serializer and the bit-stuffer/NRZI encoder in the USB transmit path.

---
 rtl/usb_crc_pkg.sv | 24 ++
 rtl/crc16_lfsr_step.sv | 25 ++
 rtl/crc16_tx_gen.sv | 169 ++++++++++++++++
 tb/tb_crc16_tx_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_crc_pkg.sv
// -----------------------------------------------------------------------------
// usb_crc_pkg
// Shared constants and types for the USB CRC16 transmit generator and the
// receive-side checker.
//   CRC16_POLY     : generator polynomial, x^16 term implicit
//   CRC16_INIT     : accumulator seed after reset or clear
//   CRC16_RESIDUAL : accumulator value after a good packet plus its
//                    complemented CRC has been fed through the LFSR
//   crc_tx_state_t : ACCUM (collect payload) / EMIT (shift out CRC field)
// -----------------------------------------------------------------------------
package usb_crc_pkg;

    localparam int          CRC16_W        = 16;
    localparam int          CRC16_CNT_W    = 5;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } crc_tx_state_t;

endpackage

// File: rtl/crc16_lfsr_step.sv
// -----------------------------------------------------------------------------
// crc16_lfsr_step
// Combinational single-bit CRC16 LFSR update, shared by TX generator and RX
// checker: t = q[15] ^ bit_in ; q_next = (q << 1) ^ (t ? POLY : 0).
// Ports:
//   q      in  16 : current accumulator
//   bit_in in  1  : bit being folded in
//   q_next out 16 : accumulator after this bit
// -----------------------------------------------------------------------------
module crc16_lfsr_step
    import usb_crc_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY
) (
    input  logic [15:0] q,
    input  logic        bit_in,
    output logic [15:0] q_next
);

    logic feedback;

    assign feedback = q[15] ^ bit_in;
    assign q_next   = {q[14:0], 1'b0} ^ (feedback ? POLY : 16'h0000);

endmodule

// File: rtl/crc16_tx_gen.sv
// -----------------------------------------------------------------------------
// crc16_tx_gen
// Transmit-side USB CRC16 generator. Accumulates the CRC over payload bits on
// each shift_en strobe, then on crc_start emits the 16 complemented CRC bits
// MSB-first on the same strobe so the packet ends with a valid CRC16 field.
//
// Ports:
//   clk        in  1 : clock
//   n_rst      in  1 : asynchronous active-low reset
//   clear      in  1 : synchronous reseed of the accumulator, aborts emission
//   data_bit   in  1 : payload bit transmitted this strobe
//   shift_en   in  1 : one-cycle bit strobe from the TX bit timer
//   crc_start  in  1 : payload finished, begin emitting the CRC field
//   crc_bit    out 1 : current CRC bit, valid while crc_active
//   crc_active out 1 : high while the CRC field is being emitted
//   crc_done   out 1 : one-cycle pulse after the 16th CRC bit shifted out
//   crc_err    out 1 : (CRC16_TX_SELFCHK_EN only) pulses with crc_done when
//                      the emitted field fails the residual self-check
//
// Build option: define CRC16_TX_SELFCHK_EN to feed emitted bits back through
// the accumulator and compare against the CRC16 residual on the 16th bit.
// Priority of controls: clear > crc_start > shift_en.
// -----------------------------------------------------------------------------
module crc16_tx_gen
    import usb_crc_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY,
    parameter logic [15:0] INIT = CRC16_INIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic data_bit,
    input  logic shift_en,
    input  logic crc_start,
    output logic crc_bit,
    output logic crc_active,
    output logic crc_done
`ifdef CRC16_TX_SELFCHK_EN
    ,
    output logic crc_err
`endif
);

    crc_tx_state_t            state_q, state_d;
    logic [CRC16_W-1:0]       q_q, q_d;        // CRC accumulator
    logic [CRC16_W-1:0]       sr_q, sr_d;      // outgoing CRC shift register
    logic [CRC16_CNT_W-1:0]   cnt_q, cnt_d;    // emitted-bit counter
    logic                     crc_active_q, crc_active_d;
    logic                     crc_done_q, crc_done_d;
`ifdef CRC16_TX_SELFCHK_EN
    logic                     crc_err_q, crc_err_d;
`endif

    logic                     step_bit;
    logic [CRC16_W-1:0]       q_step;

    // One LFSR step is enough: payload bits feed it in ACCUM, and with the
    // self-check the emitted CRC bits feed it in EMIT.
`ifdef CRC16_TX_SELFCHK_EN
    assign step_bit = (state_q == EMIT) ? sr_q[CRC16_W-1] : data_bit;
`else
    assign step_bit = data_bit;
`endif

    crc16_lfsr_step #(
        .POLY (POLY)
    ) u_step (
        .q      (q_q),
        .bit_in (step_bit),
        .q_next (q_step)
    );

    // NOTE: every signal written here gets a default first so no path through
    // the case/if tree leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        crc_done_d = 1'b0;
`ifdef CRC16_TX_SELFCHK_EN
        crc_err_d  = 1'b0;
`endif

        if (clear) begin
            state_d = ACCUM;
            q_d     = INIT;
            sr_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (shift_en) begin
                        q_d = q_step;
                    end
                    // A strobe coinciding with crc_start is part of the
                    // payload, so the field is built from the updated value.
                    if (crc_start) begin
                        sr_d    = ~(shift_en ? q_step : q_q);
                        cnt_d   = '0;
                        state_d = EMIT;
                    end
                end

                EMIT: begin
                    if (shift_en) begin
                        sr_d  = {sr_q[CRC16_W-2:0], 1'b0};
                        cnt_d = cnt_q + 5'd1;
`ifdef CRC16_TX_SELFCHK_EN
                        q_d   = q_step;
`endif
                        if (cnt_q == 5'd15) begin
                            state_d    = ACCUM;
                            q_d        = INIT;
                            crc_done_d = 1'b1;
`ifdef CRC16_TX_SELFCHK_EN
                            crc_err_d  = (q_step != CRC16_RESIDUAL);
`endif
                        end
                    end
                end

                default: begin
                    state_d = ACCUM;
                    q_d     = INIT;
                end
            endcase
        end

        crc_active_d = (state_d == EMIT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ACCUM;
            q_q          <= INIT;
            sr_q         <= '0;
            cnt_q        <= '0;
            crc_active_q <= 1'b0;
            crc_done_q   <= 1'b0;
`ifdef CRC16_TX_SELFCHK_EN
            crc_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            crc_active_q <= crc_active_d;
            crc_done_q   <= crc_done_d;
`ifdef CRC16_TX_SELFCHK_EN
            crc_err_q    <= crc_err_d;
`endif
        end
    end

    // The shift register MSB is itself a flop, so crc_bit is registered and
    // reads 0 whenever no field is in flight.
    assign crc_bit    = sr_q[CRC16_W-1];
    assign crc_active = crc_active_q;
    assign crc_done   = crc_done_q;
`ifdef CRC16_TX_SELFCHK_EN
    assign crc_err    = crc_err_q;
`endif

endmodule

// File: tb/tb_crc16_tx_gen.sv
// -----------------------------------------------------------------------------
// tb_crc16_tx_gen
// Self-checking bench for crc16_tx_gen: a table of short directed packets
// with hand-computed CRC fields, hand-written sequences for clear, reset and
// back-to-back corner cases, and random payloads against a bit-serial model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_crc16_tx_gen;

    logic clk = 1'b0;
    logic n_rst;
    logic clear;
    logic data_bit;
    logic shift_en;
    logic crc_start;
    logic crc_bit;
    logic crc_active;
    logic crc_done;
`ifdef CRC16_TX_SELFCHK_EN
    logic crc_err;
`endif

    int checks   = 0;
    int failures = 0;

    crc16_tx_gen dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .data_bit   (data_bit),
        .shift_en   (shift_en),
        .crc_start  (crc_start),
        .crc_bit    (crc_bit),
        .crc_active (crc_active),
        .crc_done   (crc_done)
`ifdef CRC16_TX_SELFCHK_EN
        ,
        .crc_err    (crc_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        int          nbits;   // payload length, first bit sent is bits[nbits-1]
        logic [15:0] bits;
        bit          sws;     // last payload bit shares the crc_start cycle
        logic [15:0] exp;     // emitted field, MSB first
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_bit(input logic b, input int gap_max);
        data_bit = b;
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        data_bit = 1'b0;
        repeat ($urandom_range(gap_max)) tick();
    endtask

    task automatic start_crc(input bit with_shift, input logic b, input string name);
        crc_start = 1'b1;
        shift_en  = with_shift;
        data_bit  = b;
        tick();
        crc_start = 1'b0;
        shift_en  = 1'b0;
        data_bit  = 1'b0;
        check({name, ".active_rise"}, {31'd0, crc_active}, 32'd1);
        check({name, ".done_low"}, {31'd0, crc_done}, 32'd0);
    endtask

    // Collects the 16 emitted bits; ends in the cycle crc_done should be high.
    // poke_idx >= 0 raises crc_start (and data_bit) on that strobe.
    task automatic emit(input logic [15:0] exp, input string name,
                        input int gap_max, input int poke_idx);
        logic [15:0] got;
        got = '0;
        for (int i = 0; i < 16; i++) begin
            got      = {got[14:0], crc_bit};
            shift_en = 1'b1;
            if (i == poke_idx) begin
                crc_start = 1'b1;
                data_bit  = 1'b1;
            end
            tick();
            shift_en  = 1'b0;
            crc_start = 1'b0;
            data_bit  = 1'b0;
            if (i != 15) repeat ($urandom_range(gap_max)) tick();
        end
        check({name, ".field"}, {16'd0, got}, {16'd0, exp});
        check({name, ".active_fall"}, {31'd0, crc_active}, 32'd0);
        check({name, ".done_pulse"}, {31'd0, crc_done}, 32'd1);
`ifdef CRC16_TX_SELFCHK_EN
        check({name, ".no_err"}, {31'd0, crc_err}, 32'd0);
`endif
    endtask

    task automatic idle_done_low(input string name);
        tick();
        check({name, ".done_one_cycle"}, {31'd0, crc_done}, 32'd0);
    endtask

    initial begin
        logic [15:0] mq;
        logic        b;
        int          nbits;

        vecs[0] = '{name: "empty",     nbits: 0, bits: 16'h0000, sws: 1'b0, exp: 16'h0000};
        vecs[1] = '{name: "one_1",     nbits: 1, bits: 16'h0001, sws: 1'b0, exp: 16'h0001};
        vecs[2] = '{name: "one_0",     nbits: 1, bits: 16'h0000, sws: 1'b0, exp: 16'h8004};
        vecs[3] = '{name: "one_0_sws", nbits: 1, bits: 16'h0000, sws: 1'b1, exp: 16'h8004};
        vecs[4] = '{name: "two_11",    nbits: 2, bits: 16'h0003, sws: 1'b0, exp: 16'h0003};
        vecs[5] = '{name: "two_00",    nbits: 2, bits: 16'h0000, sws: 1'b0, exp: 16'h0009};

        n_rst     = 1'b0;
        clear     = 1'b0;
        data_bit  = 1'b0;
        shift_en  = 1'b0;
        crc_start = 1'b0;
        #12;
        check("reset.crc_bit",    {31'd0, crc_bit},    32'd0);
        check("reset.crc_active", {31'd0, crc_active}, 32'd0);
        check("reset.crc_done",   {31'd0, crc_done},   32'd0);
        n_rst = 1'b1;
        tick();

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < vecs[v].nbits; j++) begin
                if (!(vecs[v].sws && j == vecs[v].nbits - 1))
                    feed_bit(vecs[v].bits[vecs[v].nbits - 1 - j], 1);
            end
            if (vecs[v].sws)
                start_crc(1'b1, vecs[v].bits[0], vecs[v].name);
            else
                start_crc(1'b0, 1'b0, vecs[v].name);
            emit(vecs[v].exp, vecs[v].name, 1, -1);
            idle_done_low(vecs[v].name);
        end

        // crc_start and data_bit during EMIT are ignored.
        start_crc(1'b0, 1'b0, "start_in_emit");
        emit(16'h0000, "start_in_emit", 0, 5);
        idle_done_low("start_in_emit");

        // Back-to-back: next crc_start (with a shared payload bit) in the
        // cycle crc_done is high; the accumulator must already be reseeded.
        start_crc(1'b0, 1'b0, "b2b_a");
        emit(16'h0000, "b2b_a", 0, -1);
        start_crc(1'b1, 1'b1, "b2b_b");
        emit(16'h0001, "b2b_b", 0, -1);
        idle_done_low("b2b_b");

        // clear after the 8th emitted bit aborts without crc_done.
        feed_bit(1'b1, 0);
        start_crc(1'b0, 1'b0, "clr_emit");
        repeat (8) feed_bit(1'b0, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_emit.active_drop", {31'd0, crc_active}, 32'd0);
        check("clr_emit.no_done",     {31'd0, crc_done},   32'd0);
        check("clr_emit.bit_low",     {31'd0, crc_bit},    32'd0);
        tick();
        check("clr_emit.no_done_later", {31'd0, crc_done}, 32'd0);
        start_crc(1'b0, 1'b0, "after_clr");
        emit(16'h0000, "after_clr", 1, -1);
        idle_done_low("after_clr");

        // clear during ACCUM reseeds the accumulator.
        feed_bit(1'b1, 0);
        feed_bit(1'b0, 0);
        feed_bit(1'b1, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        feed_bit(1'b1, 0);
        start_crc(1'b0, 1'b0, "clr_accum");
        emit(16'h0001, "clr_accum", 0, -1);
        idle_done_low("clr_accum");

        // Asynchronous reset in the middle of an emission.
        feed_bit(1'b0, 0);
        start_crc(1'b0, 1'b0, "rst_mid");
        check("rst_mid.first_bit", {31'd0, crc_bit}, 32'd1);
        feed_bit(1'b0, 0);
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_mid.active", {31'd0, crc_active}, 32'd0);
        check("rst_mid.bit",    {31'd0, crc_bit},    32'd0);
        check("rst_mid.done",   {31'd0, crc_done},   32'd0);
        tick();
        n_rst = 1'b1;
        tick();
        feed_bit(1'b1, 0);
        start_crc(1'b0, 1'b0, "after_rst");
        emit(16'h0001, "after_rst", 0, -1);
        idle_done_low("after_rst");

        // Random payloads back-to-back with random strobe gaps.
        for (int p = 0; p < 4; p++) begin
            mq    = 16'hFFFF;
            nbits = 8 * $urandom_range(64, 1);
            for (int j = 0; j < nbits; j++) begin
                b  = 1'($urandom_range(1));
                mq = {mq[14:0], 1'b0} ^ ((mq[15] ^ b) ? 16'h8005 : 16'h0000);
                feed_bit(b, 2);
            end
            start_crc(1'b0, 1'b0, $sformatf("rand%0d", p));
            emit(~mq, $sformatf("rand%0d", p), 2, -1);
        end
        idle_done_low("rand_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
